// File: rtl/secret_pin_gen_if.sv
// secret_pin_gen handshake bundle.
// Control in, PIN digits and status out.
interface secret_pin_gen_if;
  logic        i_generate;
  logic        i_seedLoad;
  logic [15:0] i_seedValue;
  logic        o_busy;
  logic        o_pinValid;
  logic [3:0]  o_pinDigit0;
  logic [3:0]  o_pinDigit1;
  logic [3:0]  o_pinDigit2;
  logic [3:0]  o_pinDigit3;

  modport master (
    output i_generate, i_seedLoad, i_seedValue,
    input  o_busy, o_pinValid,
    input  o_pinDigit0, o_pinDigit1,
    input  o_pinDigit2, o_pinDigit3
  );

  modport slave (
    input  i_generate, i_seedLoad, i_seedValue,
    output o_busy, o_pinValid,
    output o_pinDigit0, o_pinDigit1,
    output o_pinDigit2, o_pinDigit3
  );
endinterface

// File: rtl/secret_pin_gen.sv
// secret_pin_gen: four-digit BCD PIN from a free-running
// 16-bit LFSR with rejection of nibbles >= 10.
module secret_pin_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset_n,
  secret_pin_gen_if.slave  bus
);

  // A zero LFSR would lock up, so zero seeds become 1.
  localparam logic [15:0] LP_SEED =
    (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_lfsr;
  logic [15:0]     w_lfsr_nxt;
  logic [1:0]      r_idx;
  logic [1:0]      w_idx_nxt;
  logic [3:0][3:0] r_stage;
  logic [3:0][3:0] r_pin;
  logic [3:0]      w_cand;
  logic            w_accept;
  logic            w_last;
  logic            w_fb;

  assign w_cand = r_lfsr[3:0];
  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Seed load wins over the free-running shift.
  always_comb begin
    w_lfsr_nxt = {r_lfsr[14:0], w_fb};
    if (bus.i_seedLoad) begin
      w_lfsr_nxt = (bus.i_seedValue == 16'h0000) ?
                   16'h0001 : bus.i_seedValue;
    end
  end

  // LFSR register, advances every edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_lfsr <= LP_SEED;
    else          r_lfsr <= w_lfsr_nxt;
  end

  // Next-state, digit index and accept decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_generate) begin
          w_state_nxt = S_DRAW;
          w_idx_nxt   = 2'd0;
        end
      end
      S_DRAW: begin
        w_accept = (w_cand <= 4'd9);
        if (w_accept) begin
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_last      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.i_generate) begin
          w_state_nxt = S_DRAW;
          w_idx_nxt   = 2'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Staging digits; the last digit bypasses staging
  // so the PIN is published on the accepting edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
      r_pin   <= '0;
    end else begin
      if (w_accept) r_stage[r_idx] <= w_cand;
      if (w_last) begin
        r_pin <= {w_cand, r_stage[2], r_stage[1], r_stage[0]};
      end
    end
  end

  assign bus.o_busy      = (r_state == S_DRAW);
  assign bus.o_pinValid  = (r_state == S_DONE);
  assign bus.o_pinDigit0 = r_pin[0];
  assign bus.o_pinDigit1 = r_pin[1];
  assign bus.o_pinDigit2 = r_pin[2];
  assign bus.o_pinDigit3 = r_pin[3];

endmodule

// File: tb/tb_secret_pin_gen.sv
// Directed bench for secret_pin_gen.
// Digits are compared packed as {d3,d2,d1,d0}.
module tb_secret_pin_gen;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  secret_pin_gen_if u_if ();

  secret_pin_gen #(.SEED(16'hACE1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] digits();
    return {u_if.o_pinDigit3, u_if.o_pinDigit2,
            u_if.o_pinDigit1, u_if.o_pinDigit0};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // One generate at edge t0, then n DRAW edges to completion.
  task automatic draw(input string tag,
                      input logic [15:0] seed,
                      input logic ld,
                      input int n,
                      input logic [15:0] oldd,
                      input logic [15:0] newd,
                      input int pulse_at);
    u_if.i_seedLoad  = ld;
    u_if.i_seedValue = seed;
    u_if.i_generate  = 1'b1;
    tick();
    u_if.i_seedLoad  = 1'b0;
    u_if.i_generate  = 1'b0;
    chk({tag, "_busy_t0"}, 32'(u_if.o_busy), 32'd1);
    chk({tag, "_valid_t0"}, 32'(u_if.o_pinValid), 32'd0);
    for (int k = 1; k < n; k++) begin
      u_if.i_generate = (k == pulse_at);
      tick();
      u_if.i_generate = 1'b0;
      chk({tag, "_busy"}, 32'(u_if.o_busy), 32'd1);
      chk({tag, "_valid"}, 32'(u_if.o_pinValid), 32'd0);
      chk({tag, "_hold"}, 32'(digits()), 32'(oldd));
    end
    tick();
    chk({tag, "_valid_end"}, 32'(u_if.o_pinValid), 32'd1);
    chk({tag, "_busy_end"}, 32'(u_if.o_busy), 32'd0);
    chk({tag, "_digits"}, 32'(digits()), 32'(newd));
  endtask

  initial begin
    reset_n          = 1'b0;
    u_if.i_generate  = 1'b0;
    u_if.i_seedLoad  = 1'b0;
    u_if.i_seedValue = 16'h0000;
    repeat (3) tick();
    chk("rst_busy", 32'(u_if.o_busy), 32'd0);
    chk("rst_valid", 32'(u_if.o_pinValid), 32'd0);
    chk("rst_digits", 32'(digits()), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", 32'(u_if.o_busy), 32'd0);
      chk("idle_valid", 32'(u_if.o_pinValid), 32'd0);
      chk("idle_digits", 32'(digits()), 32'd0);
    end

    // 0001,0002,0004,0008 -> {1,2,4,8}
    draw("seed1", 16'h0001, 1'b1, 4, 16'h0000, 16'h8421, 0);
    // 000A rejected, then 0014,0028,0050,00A0 -> {4,8,0,0}
    draw("rej", 16'h000A, 1'b1, 5, 16'h8421, 16'h0084, 0);
    // zero seed behaves as 0001
    draw("zero", 16'h0000, 1'b1, 4, 16'h0084, 16'h8421, 0);
    draw("rej2", 16'h000A, 1'b1, 5, 16'h8421, 16'h0084, 0);
    // regenerate from DONE with a stray generate mid-draw
    draw("regen", 16'h0001, 1'b1, 4, 16'h0084, 16'h8421, 2);
    repeat (3) tick();
    chk("done_stay", 32'(u_if.o_pinValid), 32'd1);

    // Reset during the 2nd DRAW cycle
    u_if.i_seedLoad  = 1'b1;
    u_if.i_seedValue = 16'h0001;
    u_if.i_generate  = 1'b1;
    tick();
    u_if.i_seedLoad  = 1'b0;
    u_if.i_generate  = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_busy", 32'(u_if.o_busy), 32'd0);
    chk("mid_valid", 32'(u_if.o_pinValid), 32'd0);
    chk("mid_digits", 32'(digits()), 32'd0);
    chk("mid_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);
    tick();
    reset_n = 1'b1;
    // Generate on the first edge: ACE1 -> 59C3,B387,670F,
    // CE1E,9C3C,3879,70F2 -> {3,7,9,2}
    draw("seedp", 16'h0000, 1'b0, 7, 16'h0000, 16'h2973, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/secret_pin_gen.md
# secret_pin_gen

Generates the four-digit secret PIN (each digit 0–9) for the PIN-guessing game.
- Sits directly upstream of the guess datapath: its four digit outputs drive the secret-value inputs of the per-display equality checks.
- Its `pinValid` handshake is consumed by the main game FSM in its SETPIN state.
- Digits come from a free-running 16-bit LFSR with rejection sampling, so the value depends on when the player triggers generation.

## Interface
Parameters:
- `SEED`, default 16'hACE1: LFSR value loaded at reset. Must be nonzero; a zero value is replaced by 16'h0001.

Ports:
- `clock`  input  1: single clock; all state changes on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `generate`  input  1: request a new PIN. Sampled at the rising edge; level or pulse both work.
- `seedLoad`  input  1: load `seedValue` into the LFSR at this edge.
- `seedValue`  input  16: reseed value; 16'h0000 loads 16'h0001.
- `busy`  output  1: high while digits are being drawn.
- `pinValid`  output  1: high while the four digit outputs hold a completed PIN.
- `pinDigit0` .. `pinDigit3`  output  4 each: secret digits, BCD 0–9. `pinDigit0` feeds display 0.

## Operation
- LFSR, Fibonacci form, polynomial x^16+x^14+x^13+x^11+1:
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances on every edge in every state, except when `seedLoad` is high at that edge (then load only).
  - Never reaches zero.
- The candidate digit is the current `lfsr[3:0]`.
- FSM has three states:
  - IDLE (reset state):
    - `generate`=1 → DRAW; digit index ← 0.
  - DRAW: each edge evaluates the candidate.
    - Candidate ≤ 9: write it into staging register [index]; index++.
    - Candidate ≥ 10: reject it; index unchanged.
    - When the 4th digit is accepted at an edge: copy staging to `pinDigit0..3` at that same edge, then go to DONE.
  - DONE:
    - `generate`=1 → DRAW; index ← 0; `pinValid` ← 0.
    - Otherwise stay.
- Outputs:
  - `busy` = (state==DRAW).
  - `pinValid` = (state==DONE).
  - `pinDigit0..3` change only at the edge entering DONE. Otherwise they hold, including through DRAW.
- Digit order: the first accepted candidate goes to `pinDigit0`, the last to `pinDigit3`.
- `generate` during DRAW is ignored; there is no restart.
- `seedLoad` priority:
  - It overrides LFSR advance at that edge.
  - It is legal in any state.
  - In DRAW it does not reset the index; drawing continues from the new LFSR value on the next edge.
  - `seedLoad` and `generate` at the same edge: the LFSR loads the seed and the FSM enters DRAW. The first DRAW edge therefore evaluates the seed's low nibble.
- Staging registers hold no architectural meaning until the copy into `pinDigit0..3`.

## Timing
- Reset (`reset_n`=0, asynchronous) forces:
  - state=IDLE, lfsr=SEED (or 16'h0001 if SEED is 0), index=0;
  - `busy`=0, `pinValid`=0, `pinDigit0..3`=4'h0, staging=0.
- Reset mid-DRAW aborts the draw; there is no partial PIN on the outputs.
- Latency:
  - `generate` sampled at edge t0 → `busy`=1 after t0.
  - Minimum 4 DRAW edges (t1..t4) → `pinValid`=1 and digits updated after t4.
  - Each rejected candidate adds one cycle.
- The m-sequence guarantees termination. Worst case is bounded by the longest run of nibbles ≥ 10 in the sequence. The consumer waits on `pinValid`; it does not use a fixed delay.
- `pinValid` falls on the edge after a `generate` is sampled in DONE. It stays low until the new PIN completes.
- `busy` and `pinValid` are never high together.
- Register outputs only; no combinational path from inputs to outputs.

## Test plan
- Reset state: hold `reset_n`=0, then release, with no `generate`. Required: `busy`=0, `pinValid`=0, all digits 0, for 20 cycles.
- Deterministic draw: `seedLoad`=1, `seedValue`=16'h0001, and `generate`=1 at the same edge. Required:
  - DRAW sees lfsr 0001, 0002, 0004, 0008.
  - Digits {0..3}={1,2,4,8}.
  - `pinValid`=1 exactly 4 edges after the generate edge.
- Rejection: `seedValue`=16'h000A together with `generate`. Required:
  - DRAW sees 000A (rejected), then 0014, 0028, 0050, 00A0.
  - Digits {4,8,0,0}.
  - `pinValid` rises after 5 DRAW edges.
- Zero seed: `seedLoad` with `seedValue`=16'h0000 together with `generate`. Required: identical results to the 16'h0001 case; the LFSR is never zero.
- Regenerate and ignore: complete a PIN, then assert `generate` in DONE. Required:
  - `pinValid` drops next cycle; old digits hold until the new PIN completes.
  - A second `generate` pulse during DRAW does not change `busy` duration or the result.
- Reset mid-draw: pull `reset_n` low during the 2nd DRAW cycle. Required: immediate IDLE, `busy`=0, `pinValid`=0, digits 0, lfsr=SEED.
